// File: rtl/interval_alarm_scheduler.sv
// Multi-slot alarm scheduler comparing armed absolute targets against the shared
// free-running microsecond time base; one-shot or periodic, with sticky pending/overrun.
module interval_alarm_scheduler #(
    parameter int unsigned NSLOTS     = 4,
    parameter int unsigned SLOT_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           microsecondsSinceBoot,
    input  logic                  writeStrobe,
    input  logic [SLOT_WIDTH-1:0] writeSlot,
    input  logic [1:0]            writeCommand,
    input  logic [31:0]           writeTarget,
    input  logic [31:0]           writePeriod,
    output logic [NSLOTS-1:0]     alarmPulse,
    output logic [NSLOTS-1:0]     alarmPending,
    output logic [NSLOTS-1:0]     alarmOverrun,
    output logic [NSLOTS-1:0]     alarmArmed
);

    localparam int unsigned TW = 32;

    localparam logic [1:0] CMD_DISARM   = 2'd0;
    localparam logic [1:0] CMD_ONESHOT  = 2'd1;
    localparam logic [1:0] CMD_PERIODIC = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } slot_state_e;

    if (NSLOTS < 1 || NSLOTS > 16 || (64'd1 << SLOT_WIDTH) < 64'(NSLOTS)) begin : g_param_check
        $error("interval_alarm_scheduler: illegal NSLOTS/SLOT_WIDTH combination");
    end

    for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
        slot_state_e   state_q;
        logic [TW-1:0] target_q;
        logic [TW-1:0] period_q;
        logic          periodic_q;
        logic          pulse_q;
        logic          pending_q;
        logic          overrun_q;

        logic [TW-1:0] diff_c;
        logic          hit_c;
        logic          expired_c;
        logic          override_c;
        logic          fire_c;

        // Wrap-safe expiry: anything up to half the time range behind now counts as due.
        assign diff_c     = microsecondsSinceBoot - target_q;
        assign hit_c      = writeStrobe && (writeSlot == SLOT_WIDTH'(i));
        assign expired_c  = (state_q == ARMED) && !diff_c[TW-1];
        assign override_c = hit_c && (writeCommand != 2'd3);
        assign fire_c     = expired_c && !override_c;

        // Fire takes priority over acknowledge; arm/disarm suppress a coincident fire.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= IDLE;
                target_q   <= '0;
                period_q   <= '0;
                periodic_q <= 1'b0;
                pulse_q    <= 1'b0;
                pending_q  <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                pulse_q <= fire_c;
                if (fire_c) begin
                    pending_q <= 1'b1;
                    overrun_q <= overrun_q | pending_q;
                    if (periodic_q) begin
                        target_q <= target_q + period_q;
                    end else begin
                        state_q <= IDLE;
                    end
                end else if (hit_c) begin
                    case (writeCommand)
                        CMD_DISARM: state_q <= IDLE;
                        CMD_ONESHOT, CMD_PERIODIC: begin
                            state_q    <= ARMED;
                            target_q   <= writeTarget;
                            period_q   <= writePeriod;
                            periodic_q <= (writeCommand == CMD_PERIODIC) && (writePeriod != '0);
                        end
                        default: begin
                            pending_q <= 1'b0;
                            overrun_q <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign alarmPulse[i]   = pulse_q;
        assign alarmPending[i] = pending_q;
        assign alarmOverrun[i] = overrun_q;
        assign alarmArmed[i]   = (state_q == ARMED);
    end

endmodule

// File: tb/tb_interval_alarm_scheduler.sv
// Bench for interval_alarm_scheduler: directed scenarios plus a randomized run,
// all checked against a slot-level behavioural model.
module tb_interval_alarm_scheduler;

    localparam int unsigned NS = 4;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   now;
    logic          stb;
    logic [SW-1:0] slot;
    logic [1:0]    cmd;
    logic [31:0]   tgt;
    logic [31:0]   per;
    logic [NS-1:0] pulse, pend, ovr, armed;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   m_target [NS];
    logic [31:0]   m_period [NS];
    logic [NS-1:0] m_armed, m_periodic, m_pending, m_overrun, m_pulse;

    interval_alarm_scheduler #(.NSLOTS(NS), .SLOT_WIDTH(SW)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .microsecondsSinceBoot(now),
        .writeStrobe          (stb),
        .writeSlot            (slot),
        .writeCommand         (cmd),
        .writeTarget          (tgt),
        .writePeriod          (per),
        .alarmPulse           (pulse),
        .alarmPending         (pend),
        .alarmOverrun         (ovr),
        .alarmArmed           (armed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_target[i] = 32'd0;
            m_period[i] = 32'd0;
        end
        m_armed = '0; m_periodic = '0; m_pending = '0; m_overrun = '0; m_pulse = '0;
    endtask

    // One clock of slot behaviour, taken from the current input values.
    task automatic model_step();
        for (int i = 0; i < NS; i++) begin
            logic [31:0] age;
            bit hit, due, fire;
            hit  = stb && (int'(slot) == i);
            age  = now - m_target[i];
            due  = m_armed[i] && (age < 32'h8000_0000);
            fire = due && !(hit && cmd != 2'd3);
            m_pulse[i] = fire;
            if (fire) begin
                m_overrun[i] = m_overrun[i] | m_pending[i];
                m_pending[i] = 1'b1;
                if (m_periodic[i]) m_target[i] = m_target[i] + m_period[i];
                else               m_armed[i]  = 1'b0;
            end else if (hit) begin
                if (cmd == 2'd0) m_armed[i] = 1'b0;
                else if (cmd == 2'd3) begin
                    m_pending[i] = 1'b0;
                    m_overrun[i] = 1'b0;
                end else begin
                    m_armed[i]    = 1'b1;
                    m_target[i]   = tgt;
                    m_period[i]   = per;
                    m_periodic[i] = (cmd == 2'd2) && (per != 0);
                end
            end
        end
    endtask

    task automatic tick();
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cmd(input int s, input logic [1:0] c, input logic [31:0] t, input logic [31:0] p);
        stb = 1'b1; slot = SW'(s); cmd = c; tgt = t; per = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; stb = 1'b0; slot = '0; cmd = '0; tgt = '0; per = '0; now = 32'd0;
        model_reset();
        tick(); tick();
        if ({pulse, pend, ovr, armed} !== 16'h0) begin
            n_fail++; $display("FAIL reset_init got=%h exp=0", {pulse, pend, ovr, armed});
        end
        n_checks++;
        rst = 1'b0;
        now = 32'd100;
        write_cmd(0, 2'd1, 32'd50, 32'd0); tick();
        stb = 1'b0; tick();
        write_cmd(0, 2'd2, 32'd200, 32'd10); tick();
        stb = 1'b0;
        if ({armed[0], pend[0]} !== 2'b11) begin
            n_fail++; $display("FAIL reset_setup armed/pend got=%b exp=11", {armed[0], pend[0]});
        end
        n_checks++;
        #2 rst = 1'b1;
        #1;
        if ({pulse, pend, ovr, armed} !== 16'h0) begin
            n_fail++; $display("FAIL reset_async got=%h exp=0", {pulse, pend, ovr, armed});
        end
        n_checks++;
        model_reset();
        tick();
        rst = 1'b0;
        now = 32'd300;
        tick(); tick();
        if ({pulse, pend, armed} !== 12'h0) begin
            n_fail++; $display("FAIL reset_after got=%h exp=0", {pulse, pend, armed});
        end
        n_checks++;
    endtask

    task automatic test_oneshot();
        now = 32'd500;
        write_cmd(1, 2'd1, 32'd1000, 32'd0); tick();
        stb = 1'b0;
        for (int t = 501; t <= 1010; t++) begin
            now = 32'(t);
            tick();
            if (pulse[1] !== (t == 1000)) begin
                n_fail++; $display("FAIL oneshot_pulse t=%0d got=%b exp=%b", t, pulse[1], (t == 1000));
            end
            n_checks++;
        end
        if ({pend[1], armed[1]} !== 2'b10) begin
            n_fail++; $display("FAIL oneshot_after pend/armed got=%b exp=10", {pend[1], armed[1]});
        end
        n_checks++;
        write_cmd(1, 2'd3, 32'd0, 32'd0); tick();
        stb = 1'b0;
        if (pend[1] !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_ack pend got=%b exp=0", pend[1]);
        end
        n_checks++;
    endtask

    task automatic test_periodic();
        now = 32'd1990;
        write_cmd(2, 2'd2, 32'd2000, 32'd100); tick();
        stb = 1'b0;
        for (int t = 1991; t <= 2350; t++) begin
            bit ep;
            ep  = (t >= 2000) && ((t - 2000) % 100 == 0);
            now = 32'(t);
            tick();
            if ({pulse[2], ovr[2]} !== {ep, (t >= 2100)}) begin
                n_fail++; $display("FAIL periodic t=%0d pulse/ovr got=%b exp=%b", t, {pulse[2], ovr[2]}, {ep, (t >= 2100)});
            end
            n_checks++;
        end
        write_cmd(2, 2'd0, 32'd0, 32'd0); tick();
        stb = 1'b0;
    endtask

    task automatic test_wrap();
        now = 32'hFFFF_FF00;
        write_cmd(1, 2'd1, 32'h0000_0010, 32'd0); tick();
        stb = 1'b0;
        for (int k = 1; k <= 32'h130; k++) begin
            now = 32'hFFFF_FF00 + 32'(k);
            tick();
            if (pulse[1] !== (now == 32'h10)) begin
                n_fail++; $display("FAIL wrap_pulse now=%h got=%b exp=%b", now, pulse[1], (now == 32'h10));
            end
            n_checks++;
        end
        now = 32'h1234_5678;
        write_cmd(1, 2'd1, now - 32'h7FFF_FFFF, 32'd0); tick();
        stb = 1'b0;
        if (pulse[1] !== 1'b0) begin
            n_fail++; $display("FAIL past_load pulse got=%b exp=0", pulse[1]);
        end
        n_checks++;
        tick();
        if ({pulse[1], armed[1]} !== 2'b10) begin
            n_fail++; $display("FAIL past_fire pulse/armed got=%b exp=10", {pulse[1], armed[1]});
        end
        n_checks++;
    endtask

    task automatic test_collision();
        now = 32'd4995;
        write_cmd(3, 2'd1, 32'd5000, 32'd0); tick();
        stb = 1'b0;
        for (int t = 4996; t < 5000; t++) begin now = 32'(t); tick(); end
        now = 32'd5000;
        write_cmd(3, 2'd0, 32'd0, 32'd0); tick();
        stb = 1'b0;
        now = 32'd5001; tick();
        if ({pulse[3], pend[3], armed[3]} !== 3'b000) begin
            n_fail++; $display("FAIL disarm_collision pulse/pend/armed got=%b exp=000", {pulse[3], pend[3], armed[3]});
        end
        n_checks++;
        now = 32'd5997;
        write_cmd(0, 2'd1, 32'd6000, 32'd0); tick();
        stb = 1'b0;
        now = 32'd5998; tick();
        now = 32'd5999; tick();
        now = 32'd6000;
        write_cmd(0, 2'd3, 32'd0, 32'd0); tick();
        stb = 1'b0;
        if ({pulse[0], pend[0], ovr[0]} !== 3'b110) begin
            n_fail++; $display("FAIL ack_collision pulse/pend/ovr got=%b exp=110", {pulse[0], pend[0], ovr[0]});
        end
        n_checks++;
    endtask

    task automatic test_catchup();
        write_cmd(2, 2'd3, 32'd0, 32'd0); tick();
        now = 32'd50000;
        write_cmd(2, 2'd2, 32'd49700, 32'd100); tick();
        stb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if ({pulse[2], ovr[2]} !== {(k < 4), (k >= 1)}) begin
                n_fail++; $display("FAIL catchup k=%0d pulse/ovr got=%b exp=%b", k, {pulse[2], ovr[2]}, {(k < 4), (k >= 1)});
            end
            n_checks++;
        end
        write_cmd(2, 2'd0, 32'd0, 32'd0); tick();
        stb = 1'b0;
    endtask

    task automatic test_invalid_slot();
        now = 32'd60000;
        write_cmd(NS, 2'd1, 32'd59000, 32'd0); tick();
        stb = 1'b0; tick(); tick();
        if ({pulse, armed} !== 8'h00) begin
            n_fail++; $display("FAIL invalid_arm pulse/armed got=%h exp=00", {pulse, armed});
        end
        n_checks++;
        write_cmd(1, 2'd1, 32'd70000, 32'd0); tick();
        write_cmd(5, 2'd0, 32'd0, 32'd0); tick();
        stb = 1'b0; tick();
        if (armed !== 4'b0010) begin
            n_fail++; $display("FAIL invalid_disarm armed got=%b exp=0010", armed);
        end
        n_checks++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            stb  = ($urandom % 4 == 0);
            slot = SW'($urandom % 8);
            cmd  = 2'($urandom % 4);
            tgt  = now + 32'($urandom % 800) - 32'd400;
            per  = ($urandom % 5 == 0) ? 32'd0 : 32'($urandom % 150);
            if ($urandom % 60 == 0) now = $urandom;
            else                    now = now + 32'($urandom % 3);
            tick();
            if ({pulse, pend, ovr, armed} !== {m_pulse, m_pending, m_overrun, m_armed}) begin
                n_fail++; $display("FAIL random c=%0d pulse/pend/ovr/armed got=%h exp=%h",
                                   c, {pulse, pend, ovr, armed}, {m_pulse, m_pending, m_overrun, m_armed});
            end
            n_checks++;
        end
        stb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_wrap();
        test_collision();
        test_catchup();
        test_invalid_slot();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
